// File: rtl/router_pkg.sv
// router_pkg: shared constants, the read-side FSM state type and the
// header-length extraction helper for the packet-aware router output FIFO.
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default byte and destination-address widths
//   LEN_W_DEF               : payload-length field width (DATA_W - ADDR_W)
//   rd_state_e              : read FSM states {HDR, BODY}
//   hdr_len()               : payload length carried in a header byte
package router_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int LEN_W_DEF  = DATA_W_DEF - ADDR_W_DEF;

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} rd_state_e;

  // Header layout is {payload_len, addr}, so dropping the address LSBs of the
  // zero-extended header leaves the payload length.
  function automatic int unsigned hdr_len(input logic [31:0] hdr_word,
                                          input int unsigned addr_w);
    return int'(hdr_word >> addr_w);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: dual-port register array used as FIFO storage.
// Synchronous write, combinational (asynchronous) read.
// Ports:
//   clock  : rising-edge clock
//   we     : write strobe
//   waddr  : write address
//   wdata  : write word
//   raddr  : read address
//   rdata  : read word at raddr (combinational)
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware router output FIFO, one per destination port.
// Each entry holds {sop_tag, data}; the read side follows packet boundaries
// using the payload-length field of each header byte.
// Ports:
//   clock, resetn (sync, active-low), soft_reset (sync flush)
//   write_enb, lfd_state, data_in      : write side (lfd_state tags a header)
//   read_enb                            : read side request
//   full, empty, almost_full            : registered occupancy flags
//   data_out, sop_out, eop_out          : registered read data and markers
//   pkt_count                           : headers currently stored
//   hdr_err                             : sticky packet-framing error
// Optional build macro ROUTER_PKT_FIFO_TRISTATE_EN: data_out floats ('z) while
// idle in HDR with no read accepted in the previous cycle (legacy bus mode).
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 14
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       soft_reset,
  input  logic                       write_enb,
  input  logic                       read_enb,
  input  logic                       lfd_state,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [DATA_W-1:0]          data_out,
  output logic                       sop_out,
  output logic                       eop_out,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       hdr_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int BCNT_W = LEN_W + 1;  // holds payload_len + 1
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AFULL_C = CNT_W'(AFULL_TH);
  localparam logic [BCNT_W-1:0] BONE    = BCNT_W'(1);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  occ, occ_n;
  logic [DATA_W:0]   rd_word_p0;
  logic              wr_acc, vld_p0;
  rd_state_e         state, state_n;
  logic [BCNT_W-1:0] byte_cnt, byte_cnt_n;
  logic              sop_n, eop_n, err_n;
  logic [DATA_W-1:0] data_p1;

  // Saturating packet counter update: clamps at DEPTH and at zero.
  function automatic logic [CNT_W-1:0] pkt_sat_next(input logic [CNT_W-1:0] c,
                                                    input logic inc,
                                                    input logic dec);
    if (inc && !dec) return (c == DEPTH_C) ? c : c + CNT_W'(1);
    if (dec && !inc) return (c == '0) ? c : c - CNT_W'(1);
    return c;
  endfunction

  assign wr_acc = write_enb && !full;
  assign vld_p0 = read_enb && !empty;

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr),
    .rdata (rd_word_p0)
  );

  always_comb begin
    occ_n = occ;
    case ({wr_acc, vld_p0})
      2'b10:   occ_n = occ + CNT_W'(1);
      2'b01:   occ_n = occ - CNT_W'(1);
      default: occ_n = occ;
    endcase
  end

  // Stage p0: classify the word at rd_ptr against the packet framing FSM.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    sop_n      = 1'b0;
    eop_n      = 1'b0;
    err_n      = hdr_err;
    if (vld_p0) begin
      if (rd_word_p0[DATA_W]) begin
        // A header always (re)starts a packet; seen mid-body it is a framing error.
        sop_n      = 1'b1;
        byte_cnt_n = BCNT_W'(hdr_len(32'(rd_word_p0[DATA_W-1:0]), ADDR_W) + 1);
        state_n    = BODY;
        if (state == BODY) err_n = 1'b1;
      end else if (state == HDR) begin
        err_n = 1'b1;
      end else begin
        byte_cnt_n = byte_cnt - BONE;
        if (byte_cnt == BONE) begin
          eop_n   = 1'b1;
          state_n = HDR;
        end
      end
    end
  end

  // Stage p1: registered state, flags and read outputs.
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      state       <= HDR;
      byte_cnt    <= '0;
      sop_out     <= 1'b0;
      eop_out     <= 1'b0;
      hdr_err     <= 1'b0;
      pkt_count   <= '0;
      data_p1     <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (vld_p0) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        data_p1 <= rd_word_p0[DATA_W-1:0];
      end
      occ         <= occ_n;
      full        <= (occ_n == DEPTH_C);
      empty       <= (occ_n == '0);
      almost_full <= (occ_n >= AFULL_C);
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      sop_out     <= sop_n;
      eop_out     <= eop_n;
      hdr_err     <= err_n;
      pkt_count   <= pkt_sat_next(pkt_count, wr_acc && lfd_state, eop_n);
    end
  end

`ifdef ROUTER_PKT_FIFO_TRISTATE_EN
  logic vld_p1;

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) vld_p1 <= 1'b0;
    else                       vld_p1 <= vld_p0;
  end

  assign data_out = (state == HDR && !vld_p1) ? 'z : data_p1;
`else
  assign data_out = data_p1;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: randomized, self-checking bench for router_pkt_fifo.
// A queue-based packet model predicts every registered output each cycle;
// directed packet scenarios are followed by random traffic with flushes.
module tb_router_pkt_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 14;

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in;
  logic       full, empty, almost_full, sop_out, eop_out, hdr_err;
  logic [7:0] data_out;
  logic [4:0] pkt_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [8:0] q[$];
  logic [7:0] m_data;
  logic       m_sop, m_eop, m_err, m_in_pkt;
  int         m_left, m_pkt;

  router_pkt_fifo dut (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .data_out    (data_out),
    .sop_out     (sop_out),
    .eop_out     (eop_out),
    .pkt_count   (pkt_count),
    .hdr_err     (hdr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Predict the post-edge state from the current model and the driven inputs.
  task automatic model_edge(input logic rstn, input logic srst, input logic we,
                            input logic re, input logic lfd, input logic [7:0] din);
    logic       wa, ra;
    logic [8:0] w;
    if (!rstn || srst) begin
      q.delete();
      m_data = 8'h00; m_sop = 0; m_eop = 0; m_err = 0;
      m_in_pkt = 0; m_left = 0; m_pkt = 0;
      return;
    end
    wa = we && (q.size() < DEPTH);
    ra = re && (q.size() > 0);
    m_sop = 0;
    m_eop = 0;
    if (ra) begin
      w = q.pop_front();
      m_data = w[7:0];
      if (w[8]) begin
        if (m_in_pkt) m_err = 1;
        m_sop    = 1;
        m_in_pkt = 1;
        m_left   = int'(w[7:2]) + 1;
      end else if (!m_in_pkt) begin
        m_err = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_eop    = 1;
          m_in_pkt = 0;
        end
      end
    end
    if (wa) q.push_back({lfd, din});
    if (wa && lfd) m_pkt++;
    if (m_eop) m_pkt--;
    if (m_pkt > DEPTH) m_pkt = DEPTH;
    if (m_pkt < 0) m_pkt = 0;
  endtask

  task automatic check_all();
    chk("full",      full,        q.size() == DEPTH);
    chk("empty",     empty,       q.size() == 0);
    chk("afull",     almost_full, q.size() >= AFULL);
    chk("data_out",  data_out,    m_data);
    chk("sop_out",   sop_out,     m_sop);
    chk("eop_out",   eop_out,     m_eop);
    chk("pkt_count", pkt_count,   m_pkt);
    chk("hdr_err",   hdr_err,     m_err);
  endtask

  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic srst);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    model_edge(resetn, srst, we, re, lfd, din);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic wr(input logic lfd, input logic [7:0] din);
    step(1'b1, 1'b0, lfd, din, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Header plus n_bytes following bytes (payloads and parity), bit 7 clear.
  task automatic wr_pkt(input logic [7:0] hdr, input int n_bytes);
    wr(1'b1, hdr);
    for (int i = 0; i < n_bytes; i++) wr(1'b0, 8'($urandom_range(0, 127)));
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
    chk("rst_empty", empty, 1);
    chk("rst_data",  data_out, 0);
    resetn = 1'b1;

    // Packet 0x39: len 14, addr 1 -> 16 bytes fills the FIFO
    wr(1'b1, 8'h39);
    chk("pkt_after_hdr", pkt_count, 1);
    for (int i = 0; i < 15; i++) wr(1'b0, 8'($urandom_range(0, 127)));
    chk("full_16", full, 1);
    chk("afull_16", almost_full, 1);
    rd();
    chk("first_sop", sop_out, 1);
    chk("first_hdr", data_out, 8'h39);
    for (int i = 0; i < 15; i++) rd();
    chk("eop_16th", eop_out, 1);
    chk("drained_empty", empty, 1);
    chk("drained_pkt", pkt_count, 0);

    // Full FIFO: simultaneous write of 0xAA must be dropped while the read proceeds
    wr_pkt(8'h39, 15);
    step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
    chk("occ15_notfull", full, 0);
    chk("occ15_afull", almost_full, 1);
    for (int i = 0; i < 15; i++) begin
      rd();
      chk("no_aa", data_out == 8'hAA, 0);
    end

    // Zero-length packet: header then parity
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h5C);
    rd();
    chk("len0_sop", sop_out, 1);
    rd();
    chk("len0_eop", eop_out, 1);
    chk("len0_parity", data_out, 8'h5C);
    chk("len0_noerr", hdr_err, 0);

    // Flush mid-body, then a clean packet
    wr_pkt(8'h39, 15);
    for (int i = 0; i < 5; i++) rd();
    step(1'b1, 1'b1, 1'b1, 8'h11, 1'b1);
    chk("flush_empty", empty, 1);
    chk("flush_pkt", pkt_count, 0);
    chk("flush_data", data_out, 0);
    wr_pkt(8'h05, 2);
    rd();
    chk("post_flush_sop", sop_out, 1);
    rd();
    rd();
    chk("post_flush_eop", eop_out, 1);
    chk("post_flush_noerr", hdr_err, 0);

    // Orphan body byte read while a header is expected
    wr(1'b0, 8'h42);
    rd();
    chk("orphan_err", hdr_err, 1);
    wr_pkt(8'h09, 3);
    repeat (4) rd();
    chk("err_sticky", hdr_err, 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("err_cleared", hdr_err, 0);

    // Random traffic with occasional headers and flushes
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 15), 8'($urandom),
           1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware successor to the router output FIFO. One instance sits per destination port, between the router's sync block (write side) and the output read interface.
- Each entry stores data plus a start-of-packet tag taken from lfd_state.
- Read side tracks packet boundaries from the header length field; reports stored-packet count, almost-full and end-of-packet.

Parameters:
- DATA_W, 8: byte width; header = {payload_len, addr}.
- ADDR_W, 2: destination-address field width in the header (LSBs).
- DEPTH, 16: entry count; power of 2, minimum 4.
- AFULL_TH, 14: almost_full asserts when occupancy >= AFULL_TH; legal range 1..DEPTH.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- soft_reset  in  1  synchronous flush (timeout from sync block)
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  marks data_in as header byte
- data_in  in  DATA_W  write data
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy >= AFULL_TH
- data_out  out  DATA_W  read data, registered
- sop_out  out  1  data_out is a header byte
- eop_out  out  1  data_out is the last (parity) byte of a packet
- pkt_count  out  $clog2(DEPTH)+1  headers currently stored
- hdr_err  out  1  sticky: non-header word read while a header was expected

Behaviour:
- Reset (resetn=0 at posedge): pointers, occupancy, pkt_count and byte counter go to 0; FSM goes to HDR. Outputs: data_out=0, sop_out=0, eop_out=0, hdr_err=0, empty=1, full=0, almost_full=0.
- Priority is resetn > soft_reset > read/write.
- soft_reset=1 has the same effect as reset. Stored data is discarded, a packet in progress is abandoned, and requests in that cycle are ignored.
- Write: accepted when write_enb && !full. Stores {lfd_state, data_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Write while full is dropped silently, including when a read occurs in the same cycle.
- Read: accepted when read_enb && !empty.
  - data_out, sop_out and eop_out update at the next posedge (1-cycle latency).
  - rd_ptr wraps modulo DEPTH.
  - Without an accepted read, data_out holds its value; sop_out and eop_out drop to 0.
- Read while empty has no effect.
- Simultaneous accepted read and write: occupancy is unchanged. Read and write at the same address are never both accepted, because full blocks the write and empty blocks the read.
- Occupancy uses $clog2(DEPTH)+1 bits. The full, empty and almost_full flags are registered and consistent with occupancy after each edge.
- Read FSM:
  - HDR state:
    - A read word with tag=1 sets sop_out and loads byte_cnt = payload_len + 1 (payloads plus parity), where payload_len = data[DATA_W-1:ADDR_W]. The FSM moves to BODY.
    - A read word with tag=0 sets hdr_err and the FSM stays in HDR. The word is still output.
  - BODY state:
    - Each read decrements byte_cnt.
    - The read that takes byte_cnt from 1 to 0 sets eop_out and returns the FSM to HDR.
    - If a tag=1 word is read in BODY, hdr_err is set and the FSM restarts on the new header.
  - payload_len = 0 gives header then parity; eop_out is set on the parity byte.
- pkt_count increments on an accepted write with lfd_state=1 and decrements on an accepted read that sets eop_out. Both in one cycle means no change. pkt_count saturates at DEPTH.
- hdr_err clears only on resetn or soft_reset.

Optional Feature:
- Macro: ROUTER_PKT_FIFO_TRISTATE_EN.
- Defined: legacy bus behaviour. data_out is driven to 'z whenever the FSM is in HDR and no read was accepted in the previous cycle, and after reset or soft_reset.
- Undefined: data_out is always driven, as specified above.

Decomposition:
- Package router_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the LEN_W = DATA_W - ADDR_W derivation;
  - the read-FSM state enum typedef {HDR, BODY};
  - a header-length extraction function.
- Sub-module router_fifo_mem: dual-port register array of width DATA_W+1 and DEPTH entries, with synchronous write and combinational read. Pointers, flags and FSM stay in the top module.

Test Plan:
- Reset, then write header 8'h39 (len 14, addr 1) with lfd_state=1, then 14 random payloads and a parity byte:
  - after the header write, pkt_count=1;
  - occupancy reaches 16, so full=1 and almost_full=1 from 14 writes.
- Read the whole packet:
  - sop_out=1 with data_out=8'h39 one cycle after the first read;
  - eop_out=1 on the 16th byte;
  - empty=1 and pkt_count=0 afterwards.
- Fill to full, then assert write_enb and read_enb together with data 8'hAA:
  - the write is dropped and the read proceeds;
  - occupancy is 15, and 8'hAA never appears on data_out.
- Write header 8'h01 (len 0), then parity 8'h5C, then read:
  - sop_out on 8'h01, then eop_out on 8'h5C;
  - no hdr_err.
- Pulse soft_reset during BODY after 5 reads:
  - next edge: empty=1, pkt_count=0, data_out=0;
  - the next header read is accepted cleanly.
- Write a tag=0 byte first, then read it:
  - hdr_err=1, and it stays set until soft_reset.
